// File: rtl/secure_fsm_pkg.sv
// Shared types for the secure mode FSM: state and command encodings, plus the
// transition table used to decide whether a command is legal in a given state.
package secure_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_RUN   = 3'd2,
        ST_LOCK  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_CFG   = 3'd1,
        CMD_RUN   = 3'd2,
        CMD_STOP  = 3'd3,
        CMD_LOCK  = 3'd4,
        CMD_CLEAR = 3'd5
    } cmd_e;

    typedef struct packed {
        logic   ok;
        state_e nxt;
    } xition_t;

    // Legal-transition table; anything not listed is a rejection that keeps the state.
    function automatic xition_t decode_cmd(input state_e st, input cmd_e op);
        xition_t r;
        r.ok  = 1'b0;
        r.nxt = st;
        case (st)
            ST_IDLE: begin
                case (op)
                    CMD_NOP:  r.ok = 1'b1;
                    CMD_CFG:  begin r.ok = 1'b1; r.nxt = ST_CFG;  end
                    CMD_LOCK: begin r.ok = 1'b1; r.nxt = ST_LOCK; end
                    default:  r.ok = 1'b0;
                endcase
            end
            ST_CFG: begin
                case (op)
                    CMD_NOP:  r.ok = 1'b1;
                    CMD_RUN:  begin r.ok = 1'b1; r.nxt = ST_RUN;  end
                    CMD_STOP: begin r.ok = 1'b1; r.nxt = ST_IDLE; end
                    CMD_LOCK: begin r.ok = 1'b1; r.nxt = ST_LOCK; end
                    default:  r.ok = 1'b0;
                endcase
            end
            ST_RUN: begin
                case (op)
                    CMD_NOP:  r.ok = 1'b1;
                    CMD_STOP: begin r.ok = 1'b1; r.nxt = ST_IDLE; end
                    CMD_LOCK: begin r.ok = 1'b1; r.nxt = ST_LOCK; end
                    default:  r.ok = 1'b0;
                endcase
            end
            ST_FAULT: begin
                case (op)
                    CMD_NOP:   r.ok = 1'b1;
                    CMD_CLEAR: begin r.ok = 1'b1; r.nxt = ST_IDLE; end
                    default:   r.ok = 1'b0;
                endcase
            end
            default: r.ok = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fsm_watchdog.sv
// Idle watchdog: loadable down-counter that fires a one-cycle expire when
// TIMEOUT consecutive enabled cycles pass without a reload. TIMEOUT=0 disables it.
module fsm_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_reload,
    output logic o_expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_expire = 1'b0;
        end else begin : g_on
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            logic [CNT_W-1:0] r_cnt;

            // The decrement that would take the counter to zero is the expiry event.
            assign o_expire = i_en & ~i_reload & (r_cnt <= CNT_W'(1));

            // Reload on acceptance, while disabled, or on expiry; otherwise count down.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= CNT_W'(TIMEOUT);
                end else if (i_reload || !i_en || o_expire) begin
                    r_cnt <= CNT_W'(TIMEOUT);
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/secure_mode_fsm.sv
// Hardened host-command mode FSM with valid/ready handshake, error response,
// consecutive-error lockout into FAULT, idle watchdog and illegal-state recovery.
// Optional build macro FSM_STATE_PARITY_EN adds an even-parity bit to the state
// register so single-bit upsets into legal codes are also caught.
module secure_mode_fsm
    import secure_fsm_pkg::*;
#(
    parameter int CMD_W     = 3,
    parameter int TIMEOUT   = 255,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd_op,
    output logic             cmd_ready,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [2:0]       state_o,
    output logic             timeout_o,
    output logic             alarm_o
);

    localparam int ERR_W = $clog2(ERR_LIMIT + 1);

    state_e           r_state;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic             r_timeout;
    logic             r_alarm;

    logic             w_acc;
    logic             w_bad_state;
    logic             w_in_range;
    xition_t          w_dec;
    logic             w_legal;
    logic [ERR_W-1:0] w_err_inc;
    logic             w_err_hit;
    logic             w_wd_en;
    logic             w_wd_expire;
    state_e           w_state_nxt;

`ifdef FSM_STATE_PARITY_EN
    logic r_par;
    assign w_bad_state = (r_state > ST_FAULT) | (^{r_state, r_par});
`else
    assign w_bad_state = (r_state > ST_FAULT);
`endif

    // LOCK is the only state that refuses commands; it is left only through rst_n.
    assign cmd_ready   = (r_state != ST_LOCK);
    assign w_acc       = cmd_valid & cmd_ready;
    assign w_in_range  = (32'(cmd_op) <= 32'(CMD_CLEAR));
    assign w_dec       = decode_cmd(r_state, cmd_e'(3'(cmd_op)));
    assign w_legal     = w_in_range & w_dec.ok & ~w_bad_state;
    assign w_err_inc   = (r_err_cnt == ERR_W'(ERR_LIMIT)) ? r_err_cnt : r_err_cnt + 1'b1;
    assign w_err_hit   = w_acc & ~w_legal & ~w_bad_state & (w_err_inc == ERR_W'(ERR_LIMIT));
    assign w_wd_en     = ((r_state == ST_CFG) | (r_state == ST_RUN)) & ~w_bad_state;

    fsm_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_wd_en),
        .i_reload (w_acc),
        .o_expire (w_wd_expire)
    );

    // Next-state selection: bad encoding > error limit > accepted command > watchdog.
    always_comb begin
        w_state_nxt = r_state;
        if (w_bad_state) begin
            w_state_nxt = ST_FAULT;
        end else if (w_err_hit) begin
            w_state_nxt = ST_FAULT;
        end else if (w_acc) begin
            if (w_legal) w_state_nxt = w_dec.nxt;
        end else if (w_wd_expire) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State register with registered response, timeout and alarm outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_err_cnt   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_alarm     <= 1'b0;
`ifdef FSM_STATE_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_acc;
            r_rsp_err   <= w_acc & ~w_legal;
            r_timeout   <= w_wd_expire & ~w_acc & ~w_bad_state;
            r_alarm     <= (w_state_nxt == ST_FAULT);
`ifdef FSM_STATE_PARITY_EN
            r_par       <= ^w_state_nxt;
`endif
            if (!w_bad_state && w_acc) begin
                r_err_cnt <= w_legal ? '0 : w_err_inc;
            end
        end
    end

    assign state_o   = r_state;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign timeout_o = r_timeout;
    assign alarm_o   = r_alarm;

endmodule

// File: tb/tb_secure_mode_fsm.sv
// Bench for secure_mode_fsm: directed scenarios followed by a randomized run,
// all checked against a table-driven behavioural model of the command protocol.
module tb_secure_mode_fsm;

    localparam int TMO  = 8;
    localparam int ELIM = 4;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_err;
    logic [2:0] state_o;
    logic       timeout_o;
    logic       alarm_o;

    int total;
    int bad;

    // Reference model: state code, consecutive rejections, idle cycles in CFG/RUN.
    int tbl [5][8];
    int m_state;
    int m_err;
    int m_idle;
    bit m_rv;
    bit m_re;
    bit m_to;

    secure_mode_fsm #(
        .CMD_W     (3),
        .TIMEOUT   (TMO),
        .ERR_LIMIT (ELIM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .state_o   (state_o),
        .timeout_o (timeout_o),
        .alarm_o   (alarm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_err = 0; m_idle = 0;
        m_rv = 0; m_re = 0; m_to = 0;
    endtask

    task automatic model_step(input bit v, input int op);
        int nxt;
        m_rv = 0; m_re = 0; m_to = 0;
        if (v && m_state != 3) begin
            m_rv   = 1;
            m_idle = 0;
            nxt    = tbl[m_state][op];
            if (nxt >= 0) begin
                m_state = nxt;
                m_err   = 0;
            end else begin
                m_re = 1;
                if (m_err < ELIM) m_err++;
                if (m_err == ELIM) m_state = 4;
            end
        end else if (m_state == 1 || m_state == 2) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_state = 0;
                m_to    = 1;
                m_idle  = 0;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},   32'(state_o),   32'(m_state));
        chk({tag, ".rsp_vld"}, 32'(rsp_valid), 32'(m_rv));
        chk({tag, ".rsp_err"}, 32'(rsp_err),   32'(m_re));
        chk({tag, ".timeout"}, 32'(timeout_o), 32'(m_to));
        chk({tag, ".alarm"},   32'(alarm_o),   32'(m_state == 4));
    endtask

    // One clock of stimulus: ready is checked before the edge, everything else after.
    task automatic step(input string tag, input bit v, input int op);
        cmd_valid = v;
        cmd_op    = 3'(op);
        #1;
        chk({tag, ".ready"}, 32'(cmd_ready), 32'(m_state != 3));
        @(posedge clk);
        model_step(v, op);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset applied between edges; outputs must clear immediately.
    task automatic do_reset(input string tag);
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        model_reset();
        chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        check_all(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        for (int s = 0; s < 5; s++)
            for (int o = 0; o < 8; o++)
                tbl[s][o] = -1;
        tbl[0][0] = 0; tbl[0][1] = 1; tbl[0][4] = 3;
        tbl[1][0] = 1; tbl[1][2] = 2; tbl[1][3] = 0; tbl[1][4] = 3;
        tbl[2][0] = 2; tbl[2][3] = 0; tbl[2][4] = 3;
        tbl[4][0] = 4; tbl[4][5] = 0;

        do_reset("rst");

        // Normal mode walk: IDLE -> CFG -> RUN -> IDLE.
        step("walk_cfg", 1, 1);
        step("walk_run", 1, 2);
        step("walk_stop", 1, 3);
        step("walk_gap", 0, 0);

        // Rejections in IDLE.
        step("rej_run", 1, 2);
        step("rej_op7", 1, 7);
        step("nop_clear", 1, 0);

        // Error limit into FAULT, then CLEAR.
        step("lim1", 1, 7);
        step("lim2", 1, 6);
        step("lim3", 1, 2);
        step("lim4", 1, 3);
        chk("lim_state", 32'(state_o), 32'd4);
        chk("lim_alarm", 32'(alarm_o), 32'd1);
        step("fault_nop", 1, 0);
        step("fault_clear", 1, 5);
        chk("clear_state", 32'(state_o), 32'd0);

        // Watchdog expiry after TMO idle cycles in CFG.
        step("wd_cfg", 1, 1);
        for (int i = 0; i < TMO; i++) step("wd_idle", 0, 0);
        chk("wd_back_idle", 32'(state_o), 32'd0);
        step("wd_after", 0, 0);

        // Acceptance on the expiry cycle wins over the watchdog.
        step("wdr_cfg", 1, 1);
        for (int i = 0; i < TMO - 1; i++) step("wdr_idle", 0, 0);
        step("wdr_race", 1, 0);
        chk("wdr_state", 32'(state_o), 32'd1);
        for (int i = 0; i < TMO; i++) step("wdr_idle2", 0, 0);
        step("wdr_stop", 1, 3);

        // LOCK from RUN holds for 100 cycles whatever is offered.
        step("lk_cfg", 1, 1);
        step("lk_run", 1, 2);
        step("lk_lock", 1, 4);
        for (int i = 0; i < 100; i++)
            step("lk_hold", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        #2;
        do_reset("lk_rst");

        // Illegal state encoding recovers to FAULT on the next edge.
        @(negedge clk);
`ifdef FSM_STATE_PARITY_EN
        force dut.r_state = secure_fsm_pkg::ST_CFG;
`else
        force dut.r_state = secure_fsm_pkg::state_e'(3'h6);
`endif
        #1;
        release dut.r_state;
        @(posedge clk);
        #1;
        m_state = 4; m_rv = 0; m_re = 0; m_to = 0; m_idle = 0;
        chk("bad_state", 32'(state_o), 32'd4);
        chk("bad_alarm", 32'(alarm_o), 32'd1);
        step("bad_clear", 1, 5);

        // Randomized traffic; LOCK is eventually left through reset.
        for (int i = 0; i < 600; i++) begin
            if (m_state == 3 && $urandom_range(0, 5) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd", 1'($urandom_range(0, 9) < 3), int'($urandom_range(0, 7)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
